superscalar_ctrl_decode: RTL and testbench
==========================================

// Module: superscalar_ctrl_decode
// PURPOSE
//  ISSUE_W-wide registered control decoder. Sits between fetch-bundle buffer and issue/rename.
//  Decodes each slot's opcode/funct into sw/lw/r/branch/jmp/hlt/func/illegal controls.
//  Kills younger slots behind a control transfer. Holds a halt FSM and a decoded-instruction counter.
//  Valid/ready handshake on both sides; one output register stage (latency 1).
// PARAMETERS
//  ISSUE_W  2   slots per bundle (1..4); slot 0 is oldest
//  INSTR_W  32  instruction width; opcode=[31:26], funct=[5:0]
//  CNT_W    32  width of decoded-instruction counter
// PORTS
//  clk             in   1            clock, all state on rising edge
//  rst_n           in   1            asynchronous active-low reset
//  flush           in   1            sync pipeline flush; also leaves HALTED
//  in_valid        in   1            bundle present
//  in_ready        out  1            bundle accepted when in_valid&&in_ready
//  in_slot_valid   in   ISSUE_W      per-slot valid inside bundle
//  in_instr        in   ISSUE_W*INSTR_W  slot i at [i*INSTR_W +: INSTR_W]
//  out_valid       out  1            decoded bundle present
//  out_ready       in   1            downstream accepts when out_valid&&out_ready
//  out_slot_valid  out  ISSUE_W      slot valid after kill
//  out_instr       out  ISSUE_W*INSTR_W  registered copy of in_instr
//  out_sw/out_lw/out_r/out_branch/out_jmp/out_hlt  out  ISSUE_W each  per-slot controls
//  out_func        out  3*ISSUE_W    per-slot ALU op
//  out_illegal     out  ISSUE_W      undefined opcode/funct
//  halted          out  1            FSM in HALTED
//  err_sticky      out  1            set on any accepted illegal slot; cleared only by reset
//  dec_count       out  CNT_W        total valid slots handed downstream
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0; all out_* vectors=0; state=RUN; halted=0; err_sticky=0; dec_count=0.
//  Decode per slot: opcodes R=000000, LW=100011, SW=101011, BEQ=000100, JMP=000010, HLT=111111.
//   R funct: ADD 100000->000, SUB 100010->001, AND 100100->010, OR 100101->011, MUL 100001->100, SLT 101010->101.
//   Unknown opcode, or R with unknown funct: illegal=1, all other flags 0, func=000.
//   Non-R: func=000. Invalid input slot: all flags 0, illegal=0.
//  Kill: k = lowest valid slot with branch|jmp|hlt|illegal. Every slot j>k gets out_slot_valid=0 and all flags 0. Slot k itself stays valid.
//  Handshake:
//   in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
//   On accept: register decoded bundle, out_valid=1.
//   Else if out_ready: out_valid=0. Output regs hold stable while out_valid && !out_ready.
//  FSM RUN/HALTED:
//   RUN->HALTED when an accepted bundle has a surviving hlt slot; the hlt bundle is still presented downstream.
//   HALTED: in_ready=0. HALTED->RUN only on flush.
//  Flush (sync, highest priority): out_valid=0, state=RUN, no accept that cycle. dec_count and err_sticky unchanged.
//  dec_count += popcount(out_slot_valid) on each output transfer (out_valid&&out_ready); wraps modulo 2^CNT_W.
//  Simultaneous in/out transfer same cycle: both happen, new bundle replaces old, full throughput.
//  Bundle with all in_slot_valid=0: accepted and passed through, count adds 0.
// STRUCTURE
//  Package ctrl_pkg: opcode/funct localparams, 3-bit func codes (ADD..SLT), state enum RUN/HALTED.
//  Sub-module ctrl_slot_decode: combinational, one instruction -> flags/func/illegal; generate ISSUE_W copies.
//  Top: kill priority chain, output regs, FSM, counter.
// TESTING
//  T1 reset mid-stream: rst_n low with out_valid=1 -> outputs all 0 immediately, halted=0, dec_count=0.
//  T2 ISSUE_W=2, {ADD r, SUB r} valid=11, out_ready=1 -> next cycle out_r=11, func={001,000}, dec_count=+2.
//  T3 {BEQ slot0, LW slot1} -> out_slot_valid=01, out_branch=01, out_lw=00.
//  T4 {LW, HLT} -> bundle output with out_hlt=10; halted=1; in_ready=0 while in_valid held; flush -> halted=0, in_ready=1.
//  T5 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no count change; out_ready=1 -> drains, back-to-back accepts.
//  T6 opcode 111000 in slot0 -> out_illegal=01, slot1 killed, err_sticky=1 persists through flush.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the superscalar control decoder: opcodes, R-type functs,
// ALU op codes, halt-FSM states and the per-slot control record.
package ctrl_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_JMP = 6'b000010;
    localparam logic [5:0] OP_HLT = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_MUL = 6'b100001;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    typedef struct packed {
        logic       sw;
        logic       lw;
        logic       r;
        logic       branch;
        logic       jmp;
        logic       hlt;
        logic       illegal;
        logic [2:0] func;
    } slot_ctl_t;

endpackage

// File: rtl/ctrl_slot_decode.sv
// Combinational decode of one instruction slot into control flags and ALU op.
// An invalid slot produces an all-zero record, including illegal.
module ctrl_slot_decode
    import ctrl_pkg::*;
(
    input  logic       valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output slot_ctl_t  ctl
);

    always_comb begin
        ctl = '0;
        if (valid) begin
            case (opcode)
                OP_R: begin
                    ctl.r = 1'b1;
                    case (funct)
                        FN_ADD:  ctl.func = ALU_ADD;
                        FN_SUB:  ctl.func = ALU_SUB;
                        FN_AND:  ctl.func = ALU_AND;
                        FN_OR:   ctl.func = ALU_OR;
                        FN_MUL:  ctl.func = ALU_MUL;
                        FN_SLT:  ctl.func = ALU_SLT;
                        default: begin
                            ctl.r       = 1'b0;
                            ctl.illegal = 1'b1;
                        end
                    endcase
                end
                OP_LW:   ctl.lw      = 1'b1;
                OP_SW:   ctl.sw      = 1'b1;
                OP_BEQ:  ctl.branch  = 1'b1;
                OP_JMP:  ctl.jmp     = 1'b1;
                OP_HLT:  ctl.hlt     = 1'b1;
                default: ctl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/superscalar_ctrl_decode.sv
// ISSUE_W-wide registered control decoder: per-slot decode, younger-slot kill
// behind control transfers, halt FSM, sticky error flag and decoded-slot counter.
module superscalar_ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ISSUE_W-1:0]         in_slot_valid,
    input  logic [ISSUE_W*INSTR_W-1:0] in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ISSUE_W-1:0]         out_slot_valid,
    output logic [ISSUE_W*INSTR_W-1:0] out_instr,
    output logic [ISSUE_W-1:0]         out_sw,
    output logic [ISSUE_W-1:0]         out_lw,
    output logic [ISSUE_W-1:0]         out_r,
    output logic [ISSUE_W-1:0]         out_branch,
    output logic [ISSUE_W-1:0]         out_jmp,
    output logic [ISSUE_W-1:0]         out_hlt,
    output logic [3*ISSUE_W-1:0]       out_func,
    output logic [ISSUE_W-1:0]         out_illegal,
    output logic                       halted,
    output logic                       err_sticky,
    output logic [CNT_W-1:0]           dec_count
);

    function automatic logic [CNT_W-1:0] popcount(input logic [ISSUE_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ISSUE_W; i++) cnt = cnt + CNT_W'(v[i]);
        return cnt;
    endfunction

    slot_ctl_t raw [ISSUE_W];

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
        ctrl_slot_decode u_dec (
            .valid  (in_slot_valid[g]),
            .opcode (in_instr[g*INSTR_W + INSTR_W - 6 +: 6]),
            .funct  (in_instr[g*INSTR_W +: 6]),
            .ctl    (raw[g])
        );
    end

    logic [ISSUE_W-1:0]   nxt_slot_valid, nxt_sw, nxt_lw, nxt_r, nxt_branch;
    logic [ISSUE_W-1:0]   nxt_jmp, nxt_hlt, nxt_illegal;
    logic [3*ISSUE_W-1:0] nxt_func;
    logic                 kill;

    // Everything younger than the oldest control-transfer/illegal slot is squashed.
    always_comb begin
        kill           = 1'b0;
        nxt_slot_valid = '0;
        nxt_sw         = '0;
        nxt_lw         = '0;
        nxt_r          = '0;
        nxt_branch     = '0;
        nxt_jmp        = '0;
        nxt_hlt        = '0;
        nxt_illegal    = '0;
        nxt_func       = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (!kill) begin
                nxt_slot_valid[i]   = in_slot_valid[i];
                nxt_sw[i]           = raw[i].sw;
                nxt_lw[i]           = raw[i].lw;
                nxt_r[i]            = raw[i].r;
                nxt_branch[i]       = raw[i].branch;
                nxt_jmp[i]          = raw[i].jmp;
                nxt_hlt[i]          = raw[i].hlt;
                nxt_illegal[i]      = raw[i].illegal;
                nxt_func[3*i +: 3]  = raw[i].func;
            end
            kill = kill | raw[i].branch | raw[i].jmp | raw[i].hlt | raw[i].illegal;
        end
    end

    logic [0:0] state;
    logic       accept;
    logic       out_xfer;

    assign halted   = (state == ST_HALTED);
    assign in_ready = (state == ST_RUN) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            out_valid      <= 1'b0;
            out_slot_valid <= '0;
            out_instr      <= '0;
            out_sw         <= '0;
            out_lw         <= '0;
            out_r          <= '0;
            out_branch     <= '0;
            out_jmp        <= '0;
            out_hlt        <= '0;
            out_func       <= '0;
            out_illegal    <= '0;
            err_sticky     <= 1'b0;
            dec_count      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= ST_RUN;
        end else begin
            if (accept) begin
                out_valid      <= 1'b1;
                out_slot_valid <= nxt_slot_valid;
                out_instr      <= in_instr;
                out_sw         <= nxt_sw;
                out_lw         <= nxt_lw;
                out_r          <= nxt_r;
                out_branch     <= nxt_branch;
                out_jmp        <= nxt_jmp;
                out_hlt        <= nxt_hlt;
                out_func       <= nxt_func;
                out_illegal    <= nxt_illegal;
                if (|nxt_hlt)     state      <= ST_HALTED;
                if (|nxt_illegal) err_sticky <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_xfer) dec_count <= dec_count + popcount(out_slot_valid);
        end
    end

endmodule

// File: tb/tb_superscalar_ctrl_decode.sv
// Directed table-driven bench for superscalar_ctrl_decode (ISSUE_W=2) plus
// hand-written stall, halt, illegal and mid-stream reset sequences.
module tb_superscalar_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_slot_valid;
    logic [63:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_slot_valid;
    logic [63:0] out_instr;
    logic [1:0]  out_sw, out_lw, out_r, out_branch, out_jmp, out_hlt, out_illegal;
    logic [5:0]  out_func;
    logic        halted;
    logic        err_sticky;
    logic [31:0] dec_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    superscalar_ctrl_decode #(.ISSUE_W(2), .INSTR_W(32), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_slot_valid  (in_slot_valid),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_slot_valid (out_slot_valid),
        .out_instr      (out_instr),
        .out_sw         (out_sw),
        .out_lw         (out_lw),
        .out_r          (out_r),
        .out_branch     (out_branch),
        .out_jmp        (out_jmp),
        .out_hlt        (out_hlt),
        .out_func       (out_func),
        .out_illegal    (out_illegal),
        .halted         (halted),
        .err_sticky     (err_sticky),
        .dec_count      (dec_count)
    );

    typedef struct {
        logic [31:0] i0, i1;
        logic [1:0]  sv, osv, r, lw, sw, br, jmp, hlt, ill;
        logic [5:0]  func;
    } vec_t;

    vec_t vt [9];

    function automatic logic [31:0] rt(input logic [5:0] funct);
        return {6'b000000, 20'h0, funct};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op);
        return {op, 26'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] sv);
        in_valid      = 1'b1;
        in_instr      = {i1, i0};
        in_slot_valid = sv;
    endtask

    logic [31:0] ADD, SUB, AND_, OR_, MUL, SLT, LW, SW, BEQ, JMP, HLT, BADOP;

    initial begin
        ADD = rt(6'b100000); SUB = rt(6'b100010); AND_ = rt(6'b100100);
        OR_ = rt(6'b100101); MUL = rt(6'b100001); SLT  = rt(6'b101010);
        LW  = it(6'b100011); SW  = it(6'b101011); BEQ  = it(6'b000100);
        JMP = it(6'b000010); HLT = it(6'b111111); BADOP = it(6'b111000);

        //          i0    i1    sv     osv    r      lw     sw     br     jmp    hlt    ill    func
        vt[0] = '{ADD,  SUB,  2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b001_000};
        vt[1] = '{AND_, OR_,  2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b011_010};
        vt[2] = '{MUL,  SLT,  2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b101_100};
        vt[3] = '{BEQ,  LW,   2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b000_000};
        vt[4] = '{LW,   SW,   2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000_000};
        vt[5] = '{JMP,  ADD,  2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'b000_000};
        vt[6] = '{LW,   BEQ,  2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 6'b000_000};
        vt[7] = '{BEQ,  ADD,  2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000_000};
        vt[8] = '{SW,   LW,   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000_000};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_slot_valid = '0; in_instr = '0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_dec_count", 64'(dec_count), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven decode vectors, full throughput with out_ready=1
        for (int v = 0; v < 9; v++) begin
            drive(vt[v].i0, vt[v].i1, vt[v].sv);
            tick();
            check($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_slot_valid", v), 64'(out_slot_valid), 64'(vt[v].osv));
            check($sformatf("v%0d_r", v), 64'(out_r), 64'(vt[v].r));
            check($sformatf("v%0d_lw", v), 64'(out_lw), 64'(vt[v].lw));
            check($sformatf("v%0d_sw", v), 64'(out_sw), 64'(vt[v].sw));
            check($sformatf("v%0d_branch", v), 64'(out_branch), 64'(vt[v].br));
            check($sformatf("v%0d_jmp", v), 64'(out_jmp), 64'(vt[v].jmp));
            check($sformatf("v%0d_hlt", v), 64'(out_hlt), 64'(vt[v].hlt));
            check($sformatf("v%0d_illegal", v), 64'(out_illegal), 64'(vt[v].ill));
            check($sformatf("v%0d_func", v), 64'(out_func), 64'(vt[v].func));
            check($sformatf("v%0d_instr", v), out_instr, {vt[v].i1, vt[v].i0});
            check($sformatf("v%0d_count", v), 64'(dec_count), 64'(exp_count));
            exp_count += int'(vt[v].osv[0]) + int'(vt[v].osv[1]);
        end
        in_valid = 1'b0;
        tick();
        check("table_count", 64'(dec_count), 64'(exp_count));
        check("table_drain_valid", 64'(out_valid), 64'd0);
        check("err_clean", 64'(err_sticky), 64'd0);

        // T5: backpressure for 3 cycles, then drain with back-to-back accepts
        drive(ADD, SUB, 2'b11);
        tick();
        out_ready = 1'b0;
        drive(LW, SW, 2'b11);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d_instr", c), out_instr, {SUB, ADD});
            check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("stall%0d_count", c), 64'(dec_count), 64'(exp_count));
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 64'(in_ready), 64'd1);
        tick();
        exp_count += 2;
        check("b2b1_instr", out_instr, {SW, LW});
        check("b2b1_count", 64'(dec_count), 64'(exp_count));
        drive(JMP, ADD, 2'b11);
        tick();
        exp_count += 2;
        check("b2b2_instr", out_instr, {ADD, JMP});
        check("b2b2_slot_valid", 64'(out_slot_valid), 64'd1);
        check("b2b2_count", 64'(dec_count), 64'(exp_count));
        in_valid = 1'b0;
        tick();
        exp_count += 1;
        check("b2b_drain_count", 64'(dec_count), 64'(exp_count));

        // T4: halt bundle is still presented, then FSM blocks input until flush
        drive(LW, HLT, 2'b11);
        tick();
        check("hlt_out_valid", 64'(out_valid), 64'd1);
        check("hlt_out_hlt", 64'(out_hlt), 64'd2);
        check("hlt_out_lw", 64'(out_lw), 64'd1);
        check("hlt_slot_valid", 64'(out_slot_valid), 64'd3);
        check("hlt_halted", 64'(halted), 64'd1);
        check("hlt_in_ready", 64'(in_ready), 64'd0);
        drive(ADD, SUB, 2'b11);
        tick();
        exp_count += 2;
        check("halted_out_valid", 64'(out_valid), 64'd0);
        check("halted_hold", 64'(halted), 64'd1);
        check("halted_in_ready", 64'(in_ready), 64'd0);
        check("halted_count", 64'(dec_count), 64'(exp_count));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_halted", 64'(halted), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;

        // T6: undefined opcode kills younger slot and sets sticky error
        drive(BADOP, ADD, 2'b11);
        tick();
        check("ill_illegal", 64'(out_illegal), 64'd1);
        check("ill_slot_valid", 64'(out_slot_valid), 64'd1);
        check("ill_r", 64'(out_r), 64'd0);
        check("ill_func", 64'(out_func), 64'd0);
        check("ill_err", 64'(err_sticky), 64'd1);
        in_valid = 1'b0;
        tick();
        exp_count += 1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("ill_err_after_flush", 64'(err_sticky), 64'd1);
        check("ill_count", 64'(dec_count), 64'(exp_count));

        // R-type with unknown funct is illegal too
        drive(rt(6'b000000), LW, 2'b11);
        tick();
        check("badfunct_illegal", 64'(out_illegal), 64'd1);
        check("badfunct_lw", 64'(out_lw), 64'd0);
        exp_count += 1;

        // T1: asynchronous reset while a bundle is presented
        drive(ADD, SUB, 2'b11);
        tick();
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        check("pre_reset_count", 64'(dec_count), 64'(exp_count));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_r", 64'(out_r), 64'd0);
        check("arst_out_func", 64'(out_func), 64'd0);
        check("arst_out_instr", out_instr, 64'd0);
        check("arst_slot_valid", 64'(out_slot_valid), 64'd0);
        check("arst_halted", 64'(halted), 64'd0);
        check("arst_err", 64'(err_sticky), 64'd0);
        check("arst_count", 64'(dec_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
